// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between the CPU datapath and the loader port.
// Three-state access FSM with round-robin tie breaking, optional loader lock and per-requester read data.
module mem_port_arbiter #(
   parameter int ADDR_W = 13,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   output logic              cpu_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_ack,
   input  logic              ldr_lock,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_command,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      SERVE,
      DONE
   } state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_LDR = 1'b1;

   state_t            r_state;
   state_t            w_next_state;
   logic              r_owner;
   logic              r_last;
   logic              w_next_owner;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_ldr_rdata;
   logic              w_owner_we;
   logic [ADDR_W-1:0] w_owner_addr;
   logic [DATA_W-1:0] w_owner_wdata;
   logic              w_serve;

   always_comb begin
      w_next_state = r_state;
      w_next_owner = r_owner;
      case (r_state)
         IDLE: begin
            if (cpu_req || ldr_req) begin
               w_next_state = SERVE;
               // on a tie the lock only holds priority once the loader already owns it
               if (cpu_req && ldr_req)
                  w_next_owner = (ldr_lock && (r_last == OWN_LDR)) ? OWN_LDR : ~r_last;
               else
                  w_next_owner = ldr_req ? OWN_LDR : OWN_CPU;
            end
         end
         SERVE:   w_next_state = DONE;
         DONE:    w_next_state = IDLE;
         default: w_next_state = IDLE;
      endcase
   end

   always_comb begin
      w_owner_we    = (r_owner == OWN_LDR) ? ldr_we    : cpu_we;
      w_owner_addr  = (r_owner == OWN_LDR) ? ldr_addr  : cpu_addr;
      w_owner_wdata = (r_owner == OWN_LDR) ? ldr_wdata : cpu_wdata;
      w_serve       = (r_state == SERVE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_owner     <= OWN_CPU;
         r_last      <= OWN_LDR;
         r_cpu_rdata <= '0;
         r_ldr_rdata <= '0;
      end else begin
         r_state <= w_next_state;
         r_owner <= w_next_owner;
         if (w_serve) begin
            r_last <= r_owner;
            if (!w_owner_we) begin
               if (r_owner == OWN_LDR)
                  r_ldr_rdata <= mem_command;
               else
                  r_cpu_rdata <= mem_command;
            end
         end
      end
   end

   assign mem_address    = w_serve ? w_owner_addr  : '0;
   assign mem_write_data = w_serve ? w_owner_wdata : '0;
   assign mem_read       = w_serve & ~w_owner_we;
   assign mem_write      = w_serve &  w_owner_we;

   assign cpu_ack   = (r_state == DONE) && (r_owner == OWN_CPU);
   assign ldr_ack   = (r_state == DONE) && (r_owner == OWN_LDR);
   assign cpu_stall = cpu_req & ~cpu_ack;
   assign busy      = (r_state != IDLE);
   assign cpu_rdata = r_cpu_rdata;
   assign ldr_rdata = r_ldr_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed vector table, multi-cycle corner sequences,
// and random two-requester traffic checked against a transaction-level arbitration model.
module tb_mem_port_arbiter;

   localparam int ADDR_W = 13;
   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cpu_req = 1'b0, cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_ack, cpu_stall;
   logic              ldr_req = 1'b0, ldr_we = 1'b0;
   logic [ADDR_W-1:0] ldr_addr = '0;
   logic [DATA_W-1:0] ldr_wdata = '0;
   logic [DATA_W-1:0] ldr_rdata;
   logic              ldr_ack;
   logic              ldr_lock = 1'b0;
   logic [ADDR_W-1:0] mem_address;
   logic [DATA_W-1:0] mem_write_data;
   logic              mem_read, mem_write;
   logic [DATA_W-1:0] mem_command;
   logic              busy;

   mem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack), .ldr_lock(ldr_lock),
      .mem_address(mem_address), .mem_write_data(mem_write_data),
      .mem_read(mem_read), .mem_write(mem_write), .mem_command(mem_command),
      .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural single-port memory seen by the arbiter
   logic [7:0] mem [0:8191];
   assign mem_command = mem_read ? mem[mem_address] : 8'h00;
   initial begin
      for (int k = 0; k < 8192; k++) mem[k] = 8'(k * 7 + 3);
      mem[5] = 8'hA7;
      forever begin
         @(posedge clk);
         if (mem_write) mem[mem_address] <= mem_write_data;
      end
   end

   int checks = 0;
   int errors = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk13(input string name, input logic [12:0] act, input logic [12:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%04h expected 0x%04h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chkint(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   typedef struct {
      logic        who;        // 0 = CPU, 1 = loader
      logic        we;
      logic [12:0] addr;
      logic [7:0]  wdata;
      logic [7:0]  exp_own;    // requester's rdata in its ack cycle
      logic [7:0]  exp_other;  // other requester's rdata, must be untouched
   } vec_t;

   vec_t vecs [8];

   task automatic run_vec(input int k, input vec_t v);
      string tag;
      tag = $sformatf("vec%0d", k);
      if (v.who) begin
         ldr_req = 1'b1; ldr_we = v.we; ldr_addr = v.addr; ldr_wdata = v.wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      end
      #1;
      chk1({tag, "_stall_req"}, cpu_stall, !v.who);
      @(negedge clk);
      chk1({tag, "_serve_rd"}, mem_read, !v.we);
      chk1({tag, "_serve_wr"}, mem_write, v.we);
      chk13({tag, "_serve_addr"}, mem_address, v.addr);
      chk8({tag, "_serve_wdata"}, mem_write_data, v.wdata);
      chk1({tag, "_serve_busy"}, busy, 1'b1);
      chk1({tag, "_serve_cack"}, cpu_ack, 1'b0);
      chk1({tag, "_serve_lack"}, ldr_ack, 1'b0);
      chk1({tag, "_serve_stall"}, cpu_stall, !v.who);
      @(negedge clk);
      chk1({tag, "_done_cack"}, cpu_ack, !v.who);
      chk1({tag, "_done_lack"}, ldr_ack, v.who);
      chk1({tag, "_done_rd"}, mem_read, 1'b0);
      chk1({tag, "_done_wr"}, mem_write, 1'b0);
      chk1({tag, "_done_stall"}, cpu_stall, 1'b0);
      chk8({tag, "_own_rdata"}, v.who ? ldr_rdata : cpu_rdata, v.exp_own);
      chk8({tag, "_other_rdata"}, v.who ? cpu_rdata : ldr_rdata, v.exp_other);
      cpu_req = 1'b0; ldr_req = 1'b0;
      @(negedge clk);
      chk1({tag, "_idle_busy"}, busy, 1'b0);
      chk1({tag, "_idle_cack"}, cpu_ack, 1'b0);
      chk1({tag, "_idle_lack"}, ldr_ack, 1'b0);
   endtask

   // reference model state for random traffic
   logic [7:0] shadow [0:8191];
   logic       m_last;
   logic       m_owner;
   int         m_grant_edge, m_ack_iter, m_free_edge;
   logic [7:0] m_cpu_rd, m_ldr_rd;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int   ack_t [$];
      logic ack_o [$];
      int   n_l, stall_bad, cpu_first, cpu_after, t4, i;
      logic win, exp_cack, exp_lack;

      vecs[0] = '{who:1'b1, we:1'b1, addr:13'h1FFF, wdata:8'h3C, exp_own:8'h00, exp_other:8'h00};
      vecs[1] = '{who:1'b0, we:1'b0, addr:13'h1FFF, wdata:8'h00, exp_own:8'h3C, exp_other:8'h00};
      vecs[2] = '{who:1'b1, we:1'b1, addr:13'h0005, wdata:8'hA7, exp_own:8'h00, exp_other:8'h3C};
      vecs[3] = '{who:1'b0, we:1'b0, addr:13'h0005, wdata:8'h00, exp_own:8'hA7, exp_other:8'h00};
      vecs[4] = '{who:1'b0, we:1'b1, addr:13'h0000, wdata:8'h55, exp_own:8'hA7, exp_other:8'h00};
      vecs[5] = '{who:1'b1, we:1'b0, addr:13'h0000, wdata:8'h00, exp_own:8'h55, exp_other:8'hA7};
      vecs[6] = '{who:1'b1, we:1'b0, addr:13'h1FFF, wdata:8'h00, exp_own:8'h3C, exp_other:8'hA7};
      vecs[7] = '{who:1'b0, we:1'b0, addr:13'h0000, wdata:8'h00, exp_own:8'h55, exp_other:8'h3C};

      do_reset();
      chk1("rst_cack", cpu_ack, 1'b0);
      chk1("rst_lack", ldr_ack, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_rd", mem_read, 1'b0);
      chk1("rst_wr", mem_write, 1'b0);
      chk13("rst_addr", mem_address, 13'h0000);
      chk8("rst_crdata", cpu_rdata, 8'h00);
      chk8("rst_lrdata", ldr_rdata, 8'h00);

      for (int k = 0; k < 8; k++) run_vec(k, vecs[k]);

      // reset in the middle of a CPU read
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
      @(negedge clk);
      chk1("midrst_pre_rd", mem_read, 1'b1);
      #2 rst = 1'b1;
      #1;
      chk1("midrst_rd", mem_read, 1'b0);
      chk1("midrst_wr", mem_write, 1'b0);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_cack", cpu_ack, 1'b0);
      chk8("midrst_crdata", cpu_rdata, 8'h00);
      chk8("midrst_lrdata", ldr_rdata, 8'h00);
      @(negedge clk);
      cpu_req = 1'b0;
      rst = 1'b0;
      n_l = 0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (cpu_ack || ldr_ack) n_l++;
      end
      chkint("midrst_no_ack", n_l, 0);

      // simultaneous continuous requests after reset: C, L, C, L
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 13'h1FFF;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk);
         if (cpu_ack && ldr_ack) chk1("tie_dual_ack", 1'b1, 1'b0);
         if (cpu_ack) begin
            ack_t.push_back(cyc); ack_o.push_back(1'b0);
            chk8("tie_crdata", cpu_rdata, 8'hA7);
         end
         if (ldr_ack) begin
            ack_t.push_back(cyc); ack_o.push_back(1'b1);
            chk8("tie_lrdata", ldr_rdata, 8'h3C);
         end
      end
      cpu_req = 1'b0; ldr_req = 1'b0;
      chk1("tie_ack_count", ack_t.size() >= 4, 1'b1);
      if (ack_t.size() >= 4) begin
         for (int k = 0; k < 4; k++) begin
            chk1($sformatf("tie_order%0d", k), ack_o[k], k[0]);
            if (k > 0) chkint($sformatf("tie_gap%0d", k), ack_t[k] - ack_t[k-1], 3);
         end
      end

      // loader lock keeps priority until released
      do_reset();
      ldr_lock = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 13'h0005;
      ldr_req = 1'b1; ldr_we = 1'b0; ldr_addr = 13'h1FFF;
      n_l = 0; stall_bad = 0; cpu_first = -1; cpu_after = -1; t4 = -1;
      for (int k = 0; k < 40 && cpu_first < 0; k++) begin
         @(negedge clk);
         if (cpu_ack) begin
            cpu_first = cyc; cpu_after = n_l;
         end else if (cpu_stall !== 1'b1) stall_bad++;
         if (ldr_ack) begin
            n_l++;
            if (n_l == 4) begin
               ldr_lock = 1'b0; t4 = cyc;
            end
         end
      end
      chk1("lock_cpu_granted", cpu_first >= 0, 1'b1);
      chkint("lock_ldr_before_cpu", cpu_after, 4);
      chkint("lock_cpu_gap", cpu_first - t4, 3);
      chkint("lock_stall_low", stall_bad, 0);

      // random traffic against the transaction-level model
      do_reset();
      for (int k = 0; k < 8192; k++) shadow[k] = mem[k];
      m_last = 1'b1; m_owner = 1'b0;
      m_grant_edge = -10; m_ack_iter = -10; m_free_edge = 0;
      m_cpu_rd = 8'h00; m_ldr_rd = 8'h00;
      for (int k = 0; k < 400; k++) begin
         @(negedge clk);
         i = cyc;
         exp_cack = (m_ack_iter == i) && !m_owner;
         exp_lack = (m_ack_iter == i) && m_owner;
         chk1("rnd_cack", cpu_ack, exp_cack);
         chk1("rnd_lack", ldr_ack, exp_lack);
         chk1("rnd_busy", busy, (i >= m_grant_edge) && (i <= m_grant_edge + 1));
         chk1("rnd_stall", cpu_stall, cpu_req & ~exp_cack);
         if (exp_cack || exp_lack) begin
            chk8("rnd_crdata", cpu_rdata, m_cpu_rd);
            chk8("rnd_lrdata", ldr_rdata, m_ldr_rd);
         end
         if (exp_cack) cpu_req = 1'b0;
         else if (!cpu_req && ($urandom % 3 == 0)) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom % 2);
            cpu_addr = ($urandom % 4 == 0) ? 13'h1FFF : 13'($urandom_range(0, 7));
            cpu_wdata = 8'($urandom);
         end
         if (exp_lack) ldr_req = 1'b0;
         else if (!ldr_req && ($urandom % 3 == 0)) begin
            ldr_req = 1'b1; ldr_we = 1'($urandom % 2);
            ldr_addr = ($urandom % 4 == 0) ? 13'h1FFF : 13'($urandom_range(0, 7));
            ldr_wdata = 8'($urandom);
         end
         if ($urandom % 16 == 0) ldr_lock = ~ldr_lock;
         // grant decision at the coming edge i+1
         if ((i + 1 >= m_free_edge) && (cpu_req || ldr_req)) begin
            if (cpu_req && ldr_req) win = (ldr_lock && m_last) ? 1'b1 : ~m_last;
            else win = ldr_req;
            m_owner = win; m_last = win;
            m_grant_edge = i + 1; m_ack_iter = i + 2; m_free_edge = i + 4;
            if (win) begin
               if (ldr_we) shadow[ldr_addr] = ldr_wdata;
               else m_ldr_rd = shadow[ldr_addr];
            end else begin
               if (cpu_we) shadow[cpu_addr] = cpu_wdata;
               else m_cpu_rd = shadow[cpu_addr];
            end
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
